// File: rtl/muldiv16_unit.sv
// muldiv16_unit: iterative 16x16 unsigned multiply (radix-2 shift-add) and
// 16/16 unsigned restoring divide. Each operation takes 16 cycles and
// produces one result bit per cycle. Divide by zero completes after 1 cycle.
module muldiv16_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] lo,
  output logic [15:0] hi,
  output logic        div_by_zero
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  // acc holds the upper partial product (mul) or the partial remainder (div).
  logic [32:0] acc_q, acc_d;
  // mq shifts the multiplier out (mul) or the dividend out / quotient in (div).
  logic [15:0] mq_q, mq_d;
  logic        done_q, done_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic        dbz_q, dbz_d;

  logic [32:0] mul_sum;
  logic [32:0] mul_acc_nx;
  logic [15:0] mul_mq_nx;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [32:0] div_acc_nx;
  logic [15:0] div_mq_nx;

  // One iteration of each algorithm, computed from the current registers.
  always_comb begin
    mul_sum    = acc_q + (mq_q[0] ? {17'd0, b_q} : 33'd0);
    mul_acc_nx = {1'b0, mul_sum[32:1]};
    mul_mq_nx  = {mul_sum[0], mq_q[15:1]};
    div_shift  = {acc_q[31:0], mq_q[15]};
    div_trial  = div_shift - {17'd0, b_q};
    if (div_trial[32]) begin
      // Trial subtraction went negative: restore and record a 0 quotient bit.
      div_acc_nx = div_shift;
      div_mq_nx  = {mq_q[14:0], 1'b0};
    end else begin
      div_acc_nx = div_trial;
      div_mq_nx  = {mq_q[14:0], 1'b1};
    end
  end

  // Next-state and register updates for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = 5'd0;
          acc_d   = 33'd0;
          mq_d    = a;
          state_d = RUN;
        end
      end
      RUN: begin
        if (op_q && (b_q == 16'd0)) begin
          // Divide by zero short-circuits on the first RUN cycle.
          lo_d    = 16'hFFFF;
          hi_d    = a_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d = op_q ? div_acc_nx : mul_acc_nx;
          mq_d  = op_q ? div_mq_nx  : mul_mq_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            lo_d    = op_q ? div_mq_nx : mul_mq_nx;
            hi_d    = op_q ? div_acc_nx[15:0] : mul_acc_nx[15:0];
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 1'b0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      acc_q   <= 33'd0;
      mq_q    <= 16'd0;
      done_q  <= 1'b0;
      lo_q    <= 16'd0;
      hi_q    <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign lo          = lo_q;
  assign hi          = hi_q;
  assign div_by_zero = dbz_q;

endmodule
